// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole scoring block.
package whack_pkg;

  localparam int SCORE_W   = 10;
  localparam int SCORE_MAX = 999;
  localparam int MOLE_W    = 18;
  localparam int CNT_W     = 5;
  localparam int TIME_W    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  // Adds a hit count to a score one bit wider than the score so that the
  // carry is visible, then clamps anything above SCORE_MAX.
  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] base,
    input logic [CNT_W-1:0]   inc
  );
    logic [SCORE_W:0] sum_s;
    sum_s = {1'b0, base} + {{(SCORE_W + 1 - CNT_W){1'b0}}, inc};
    if (sum_s > (SCORE_W + 1)'(SCORE_MAX)) begin
      sat_add = SCORE_W'(SCORE_MAX);
    end else begin
      sat_add = sum_s[SCORE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/whack_score_popcount18.sv
// Combinational population count of the 18 per-mole hit bits.
module popcount18
  import whack_pkg::*;
(
  input  logic [MOLE_W-1:0] bits,
  output logic [CNT_W-1:0]  count
);

  // Sum every hit bit into a 5-bit count (0..18).
  always_comb begin
    count = {CNT_W{1'b0}};
    for (int i = 0; i < MOLE_W; i++) begin
      count = count + {{(CNT_W - 1){1'b0}}, bits[i]};
    end
  end

endmodule

// File: rtl/whack_score.sv
// Round timer, saturating score accumulator and high-score keeper for the
// whack-a-mole game. Hits flow through a two-stage pipeline (popcount, then
// saturating add) so the score lands two cycles after the hit pulses.
module whack_score
  import whack_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GAME_SECONDS = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MOLE_W-1:0]   hit_reg,
  output logic [SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]  high_score,
  output logic [TIME_W-1:0]   time_left,
  output logic                game_active,
  output logic                game_over
);

  localparam int                 DIV_W     = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_HZ - 1);
  localparam logic [TIME_W-1:0]  TIME_LOAD = TIME_W'(GAME_SECONDS);

  state_t              state_r;
  logic [DIV_W-1:0]    div_r;
  logic [TIME_W-1:0]   time_r;
  logic [SCORE_W-1:0]  score_r;
  logic [SCORE_W-1:0]  high_r;
  logic [CNT_W-1:0]    cnt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic                vld_r;
  logic                launch_s;

  // A round may only be launched from IDLE or OVER; start during PLAY is ignored.
  assign launch_s = start && ((state_r == IDLE) || (state_r == OVER));

  popcount18 u_popcount (
    .bits  (hit_reg),
    .count (cnt_s)
  );

  // Game FSM with the one-second tick divider and the seconds countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      div_r   <= {DIV_W{1'b0}};
      time_r  <= {TIME_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= PLAY;
            div_r   <= {DIV_W{1'b0}};
            time_r  <= TIME_LOAD;
          end
        end
        PLAY: begin
          if (div_r == DIV_LAST) begin
            div_r <= {DIV_W{1'b0}};
            if (time_r > 6'd1) begin
              time_r <= time_r - 6'd1;
            end else begin
              time_r  <= {TIME_W{1'b0}};
              state_r <= OVER;
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        OVER: begin
          if (start) begin
            state_r <= PLAY;
            div_r   <= {DIV_W{1'b0}};
            time_r  <= TIME_LOAD;
          end
        end
        default: begin
          state_r <= IDLE;
          div_r   <= {DIV_W{1'b0}};
          time_r  <= {TIME_W{1'b0}};
        end
      endcase
    end
  end

  // Stage 1: register the hit count, tagged valid only if sampled in PLAY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      vld_r <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      vld_r <= (state_r == PLAY);
    end
  end

  // Stage 2: saturating score add; a new-round clear beats a pending late add.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score_r <= {SCORE_W{1'b0}};
    end else if (launch_s) begin
      score_r <= {SCORE_W{1'b0}};
    end else if (vld_r) begin
      score_r <= sat_add(score_r, cnt_r);
    end
  end

  // Track the best score while OVER; compares the pre-clear score on a relaunch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      high_r <= {SCORE_W{1'b0}};
    end else if ((state_r == OVER) && (score_r > high_r)) begin
      high_r <= score_r;
    end
  end

  assign score       = score_r;
  assign high_score  = high_r;
  assign time_left   = time_r;
  assign game_active = (state_r == PLAY);
  assign game_over   = (state_r == OVER);

endmodule
